// File: rtl/np_pkg.sv
// np_pkg: shared state encoding and colour constants for the NeoPixel frame sequencer
package np_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_READY, LOAD, GO, WAIT_ACK, WAIT_DONE} state_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  localparam rgb_t BALL_RGB   = '{r: 8'h20, g: 8'h20, b: 8'h20};
  localparam rgb_t LPAD_RGB   = '{r: 8'h00, g: 8'h00, b: 8'h30};
  localparam rgb_t RPAD_RGB   = '{r: 8'h30, g: 8'h00, b: 8'h00};
  localparam rgb_t CENTER_RGB = '{r: 8'h00, g: 8'h04, b: 8'h00};
  localparam rgb_t OFF_RGB    = '{r: 8'h00, g: 8'h00, b: 8'h00};
endpackage

// File: rtl/np_pixel_color.sv
// np_pixel_color: priority colour of one strand pixel from the frame snapshot
module np_pixel_color
  import np_pkg::*;
#(
  parameter int NUM_NPX = 17,
  localparam int PW = $clog2(NUM_NPX)
) (
  input  logic [PW-1:0] idx,
  input  logic [PW-1:0] ball_pos,
  input  logic          ball_valid,
  input  logic          left_flash,
  input  logic          right_flash,
  output rgb_t          rgb
);
  // ball beats paddles beats centre line; an off-strand ball position is never drawn
  always_comb
    rgb = (ball_valid && 32'(ball_pos) < NUM_NPX && idx == ball_pos) ? BALL_RGB :
          (idx == '0 && left_flash)                     ? LPAD_RGB :
          (idx == PW'(NUM_NPX - 1) && right_flash)      ? RPAD_RGB :
          (idx == PW'(NUM_NPX / 2))                     ? CENTER_RGB : OFF_RGB;
endmodule

// File: rtl/np_frame_sequencer.sv
// np_frame_sequencer: snapshots game state and streams one frame of pixel loads to the NeoPixel controller
module np_frame_sequencer
  import np_pkg::*;
#(
  parameter int NUM_NPX = 17,
  parameter int REFRESH_CYCLES = 833333,
  localparam int PW = $clog2(NUM_NPX)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          frame_req,
  input  logic [PW-1:0] ball_pos,
  input  logic          ball_valid,
  input  logic          left_flash,
  input  logic          right_flash,
  input  logic          np_ready,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic [PW-1:0] pixel,
  output logic          load,
  output logic          go,
  output logic          busy,
  output logic          frame_done
);
  localparam int CW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  logic [CW-1:0] cnt;
  logic tick, start, pending;
  state_t state, state_n;
  logic [PW-1:0] idx, idx_n, ball_pos_s;
  logic ball_valid_s, left_flash_s, right_flash_s;
  rgb_t col;
  assign tick = (REFRESH_CYCLES != 0) && (cnt == CW'(REFRESH_CYCLES - 1));
  assign start = (state == IDLE) && (pending || frame_req || tick);
  // free-running refresh counter, held at zero when auto-refresh is disabled
  always_ff @(posedge CLOCK_50)
    cnt <= (reset || tick || REFRESH_CYCLES == 0) ? '0 : cnt + 1'b1;
  // next-state and pixel index sequencing
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE:       state_n = start ? WAIT_READY : IDLE;
      WAIT_READY: begin
        state_n = np_ready ? LOAD : WAIT_READY;
        idx_n = np_ready ? '0 : idx;
      end
      LOAD: begin
        state_n = (idx == PW'(NUM_NPX - 1)) ? GO : LOAD;
        idx_n = idx + 1'b1;
      end
      GO:         state_n = WAIT_ACK;
      WAIT_ACK:   state_n = np_ready ? WAIT_ACK : WAIT_DONE;
      WAIT_DONE:  state_n = np_ready ? IDLE : WAIT_DONE;
      default:    state_n = IDLE;
    endcase
  end
  // state, request latch, snapshot and registered completion pulse
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      pending <= 1'b0;
      ball_pos_s <= '0;
      ball_valid_s <= 1'b0;
      left_flash_s <= 1'b0;
      right_flash_s <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      pending <= start ? 1'b0 : (pending || frame_req || tick);
      frame_done <= (state == WAIT_DONE) && np_ready;
      if (start) begin
        ball_pos_s <= ball_pos;
        ball_valid_s <= ball_valid;
        left_flash_s <= left_flash;
        right_flash_s <= right_flash;
      end
    end
  end
  np_pixel_color #(.NUM_NPX(NUM_NPX)) u_color (
    .idx(idx),
    .ball_pos(ball_pos_s),
    .ball_valid(ball_valid_s),
    .left_flash(left_flash_s),
    .right_flash(right_flash_s),
    .rgb(col)
  );
  assign load = (state == LOAD);
  assign go = (state == GO);
  assign busy = (state != IDLE);
  assign pixel = load ? idx : '0;
  assign {red, green, blue} = load ? col : OFF_RGB;
endmodule

// File: tb/tb_np_frame_sequencer.sv
// tb_np_frame_sequencer: directed frames checked against a per-cycle behavioural model plus literal pixel colours
module tb_np_frame_sequencer;
  localparam int N = 17;
  localparam int P1 = 100;
  typedef struct {
    int phase;
    int k;
    bit pend;
    int n;
    bit done;
    int bp;
    bit bv, lf, rf;
  } m_t;
  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic frame_req = 1'b0;
  logic [4:0] bp = '0;
  logic bv = 1'b0, lf = 1'b0, rf = 1'b0;
  logic rdy0 = 1'b0, rdy1 = 1'b1;
  logic [7:0] red0, green0, blue0, red1, green1, blue1;
  logic [4:0] pixel0, pixel1;
  logic load0, go0, busy0, frame_done0, load1, go1, busy1, frame_done1;
  int n_chk = 0, n_pass = 0, cyc = 0;
  m_t m0, m1;
  logic [23:0] cap [N];
  int cap_n;

  always #5 clk = ~clk;

  np_frame_sequencer #(.NUM_NPX(N), .REFRESH_CYCLES(0)) dut0 (
    .CLOCK_50(clk), .reset(rst0), .frame_req(frame_req), .ball_pos(bp), .ball_valid(bv),
    .left_flash(lf), .right_flash(rf), .np_ready(rdy0), .red(red0), .green(green0), .blue(blue0),
    .pixel(pixel0), .load(load0), .go(go0), .busy(busy0), .frame_done(frame_done0));
  np_frame_sequencer #(.NUM_NPX(N), .REFRESH_CYCLES(P1)) dut1 (
    .CLOCK_50(clk), .reset(rst1), .frame_req(1'b0), .ball_pos(bp), .ball_valid(bv),
    .left_flash(lf), .right_flash(rf), .np_ready(rdy1), .red(red1), .green(green1), .blue(blue1),
    .pixel(pixel1), .load(load1), .go(go1), .busy(busy1), .frame_done(frame_done1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // whole frame painted lowest priority first so later rules overwrite earlier ones
  function automatic logic [23:0] frame_rgb(m_t m, int i);
    logic [23:0] f [N];
    foreach (f[j]) f[j] = 24'h0;
    f[N/2] = 24'h000400;
    if (m.rf) f[N-1] = 24'h300000;
    if (m.lf) f[0] = 24'h000030;
    if (m.bv && m.bp < N) f[m.bp] = 24'h202020;
    return f[i];
  endfunction

  function automatic m_t step(m_t m, bit r, bit req, bit rdy, int period);
    bit tick, start;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    tick = period != 0 && (m.n % period == period - 1);
    m.n++;
    start = m.phase == 0 && (m.pend || req || tick);
    m.pend = start ? 1'b0 : (m.pend || req || tick);
    m.done = 1'b0;
    case (m.phase)
      0: if (start) begin m.phase = 1; m.bp = bp; m.bv = bv; m.lf = lf; m.rf = rf; end
      1: if (rdy) begin m.phase = 2; m.k = 0; end
      2: if (m.k == N - 1) m.phase = 3; else m.k++;
      3: m.phase = 4;
      4: if (!rdy) m.phase = 5;
      default: if (rdy) begin m.phase = 0; m.done = 1'b1; end
    endcase
    return m;
  endfunction

  function automatic logic [32:0] expv(m_t m);
    bit ld;
    ld = m.phase == 2;
    return {m.phase != 0, ld, m.phase == 3, m.done, ld ? 5'(m.k) : 5'd0, ld ? frame_rgb(m, m.k) : 24'h0};
  endfunction

  always @(posedge clk) begin
    cyc++;
    m0 = step(m0, rst0, frame_req, rdy0, 0);
    m1 = step(m1, rst1, 1'b0, rdy1, P1);
  end

  always @(negedge clk) begin
    chk("dut0_outputs", {busy0, load0, go0, frame_done0, pixel0, red0, green0, blue0}, expv(m0));
    chk("dut1_outputs", {busy1, load1, go1, frame_done1, pixel1, red1, green1, blue1}, expv(m1));
  end

  initial begin
    forever begin
      @(negedge clk);
      if (go1) begin
        rdy1 = 1'b0;
        repeat (3) @(negedge clk);
        rdy1 = 1'b1;
      end
    end
  end

  task automatic run0(input bit pulse, input int hold, input bit req_during, input int chg_at, input logic [4:0] chg_val);
    bit gone = 0, prev_load = 0, gotd = 0;
    int prev_pix = -1, dc;
    foreach (cap[j]) cap[j] = 24'h0;
    cap_n = 0;
    if (pulse) begin
      frame_req = 1'b1;
      @(negedge clk);
      frame_req = 1'b0;
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (go0) begin
        gone = 1;
        chk("go_after_last_load", {prev_load, 5'(prev_pix)}, {1'b1, 5'd16});
        break;
      end
      prev_load = load0;
      prev_pix = pixel0;
      if (load0) begin
        cap[pixel0] = {red0, green0, blue0};
        cap_n++;
        if (pixel0 == chg_at) bp = chg_val;
      end
    end
    chk("go_seen", gone, 1);
    rdy0 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      frame_req = req_during && (i == 20 || i == 60);
      @(negedge clk);
    end
    frame_req = 1'b0;
    rdy0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (frame_done0) begin
        gotd = 1;
        chk("busy_at_done", busy0, 0);
        break;
      end
    end
    chk("done_seen", gotd, 1);
    dc = gotd;
    repeat (3) begin
      @(negedge clk);
      dc += frame_done0;
    end
    chk("single_done", dc, 1);
  endtask

  initial begin
    int cnt, t0, t1;
    bit pb, found;
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_busy", busy0, 0);
    chk("idle_outputs", {load0, go0, frame_done0, pixel0, red0, green0, blue0}, 0);

    rdy0 = 1'b1; bp = 5; bv = 1; lf = 1; rf = 0;
    run0(1, 3, 0, -1, 0);
    chk("load_count", cap_n, 17);
    chk("pix0_lpad", cap[0], 24'h000030);
    chk("pix5_ball", cap[5], 24'h202020);
    chk("pix8_centre", cap[8], 24'h000400);
    chk("pix3_off", cap[3], 24'h0);
    chk("pix16_off", cap[16], 24'h0);

    rdy0 = 1'b0;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += load0;
    end
    chk("no_load_while_not_ready", cnt, 0);
    rdy0 = 1'b1;
    @(negedge clk);
    chk("first_load_after_ready", {load0, pixel0}, {1'b1, 5'd0});
    run0(0, 3, 0, -1, 0);

    run0(1, 100, 1, -1, 0);
    run0(0, 3, 0, -1, 0);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      cnt += busy0;
    end
    chk("collapsed_requests_idle", cnt, 0);

    bp = 16; lf = 0; rf = 1;
    run0(1, 3, 0, -1, 0);
    chk("ball_over_rpad", cap[16], 24'h202020);
    bp = 20;
    run0(1, 3, 0, -1, 0);
    chk("offstrand_rpad", cap[16], 24'h300000);
    cnt = 0;
    foreach (cap[j]) cnt += (cap[j] == 24'h202020);
    chk("offstrand_no_ball", cnt, 0);
    bp = 10;
    run0(1, 3, 0, 2, 12);
    chk("snapshot_ball", cap[10], 24'h202020);
    chk("snapshot_ignores_change", cap[12], 24'h0);

    rst1 = 1'b0;
    t0 = -1; t1 = -1; pb = 0;
    for (int i = 0; i < 400 && t1 < 0; i++) begin
      @(negedge clk);
      if (busy1 && !pb) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
      pb = busy1;
    end
    chk("refresh_period", 64'(t1 - t0), 100);
    found = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (load1 && pixel1 == 7) begin
        found = 1;
        break;
      end
    end
    chk("idx7_seen", found, 1);
    rst1 = 1'b1;
    @(negedge clk);
    chk("reset_mid_load", {load1, go1, busy1}, 0);
    rst1 = 1'b0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
